// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: watches a multiplexed active-low 7-segment bus and
// recovers per-digit hex values once each dwell has been stable long enough.
module seg7_scan_decoder #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_DIGITS-1:0]         an,
   input  logic [6:0]                    seg,
   output logic [4*NUM_DIGITS-1:0]       digits,
   output logic [NUM_DIGITS-1:0]         valid,
   output logic [NUM_DIGITS-1:0]         invalid,
   output logic                          update,
   output logic [$clog2(NUM_DIGITS)-1:0] update_idx,
   output logic                          frame_done
);

   localparam int         IW = $clog2(NUM_DIGITS);
   localparam logic [7:0] SC = 8'(STABLE_CYCLES);

   typedef enum logic [1:0] {
      IDLE,
      TRACK,
      HOLD
   } state_t;

   state_t                state, state_n;
   logic [7:0]            cnt, cnt_n;
   logic [NUM_DIGITS-1:0] s_an;
   logic [6:0]            s_seg;
   logic [NUM_DIGITS-1:0] seen, seen_set;
   logic [NUM_DIGITS-1:0] an_l;
   logic                  onehot, same, commit, full;
   logic [IW-1:0]         idx;
   logic [4:0]            dv;

   function automatic logic [4:0] dec7(input logic [6:0] s);
      logic [4:0] r;
      case (s)
         7'b1000000: r = 5'h10;
         7'b1111001: r = 5'h11;
         7'b0100100: r = 5'h12;
         7'b0110000: r = 5'h13;
         7'b0011001: r = 5'h14;
         7'b0010010: r = 5'h15;
         7'b0000010: r = 5'h16;
         7'b1111000: r = 5'h17;
         7'b0000000: r = 5'h18;
         7'b0010000: r = 5'h19;
         7'b0001000: r = 5'h1a;
         7'b0000011: r = 5'h1b;
         7'b1000110: r = 5'h1c;
         7'b0100001: r = 5'h1d;
         7'b0000110: r = 5'h1e;
         7'b0001110: r = 5'h1f;
         default:    r = 5'h00;
      endcase
      return r;
   endfunction

   assign an_l   = ~an;
   assign onehot = (an_l != '0) &&
                   ((an_l & (an_l - NUM_DIGITS'(1))) == '0);
   assign same   = (an == s_an) && (seg == s_seg);

   // The committed dwell is the one held in the sample registers.
   always_comb begin
      idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (!s_an[i]) idx = IW'(i);
   end

   assign dv       = dec7(s_seg);
   assign seen_set = seen | (NUM_DIGITS'(1) << idx);
   assign full     = &seen_set;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      commit  = 1'b0;
      unique case (state)
         IDLE: begin
            if (onehot) begin
               state_n = TRACK;
               cnt_n   = 8'd1;
            end else begin
               cnt_n = 8'd0;
            end
         end
         TRACK: begin
            commit = (cnt == SC);
            if (same) begin
               if (cnt == SC) state_n = HOLD;
               else           cnt_n   = cnt + 8'd1;
            end else if (onehot) begin
               cnt_n = 8'd1;
            end else begin
               state_n = IDLE;
               cnt_n   = 8'd0;
            end
         end
         HOLD: begin
            if (!same) begin
               if (onehot) begin
                  state_n = TRACK;
                  cnt_n   = 8'd1;
               end else begin
                  state_n = IDLE;
                  cnt_n   = 8'd0;
               end
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= 8'd0;
         s_an       <= '1;
         s_seg      <= '1;
         seen       <= '0;
         digits     <= '0;
         valid      <= '0;
         invalid    <= '0;
         update     <= 1'b0;
         update_idx <= '0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         s_an       <= an;
         s_seg      <= seg;
         update     <= commit;
         frame_done <= commit && full;
         if (commit) begin
            update_idx <= idx;
            seen       <= full ? '0 : seen_set;
            if (dv[4]) begin
               digits[4*int'(idx) +: 4] <= dv[3:0];
               valid[idx]               <= 1'b1;
               invalid[idx]             <= 1'b0;
            end else begin
               valid[idx]   <= 1'b0;
               invalid[idx] <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: scoreboard bench; dwells push expected commits,
// a monitor pops them when update pulses and checks outputs every cycle.
module tb_seg7_scan_decoder;

   localparam int N = 4;
   localparam int S = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  an  = 4'hF;
   logic [6:0]  seg = 7'h7F;
   logic [15:0] digits;
   logic [3:0]  valid, invalid;
   logic        update, frame_done;
   logic [1:0]  update_idx;

   seg7_scan_decoder #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
      .clk(clk), .rst(rst), .an(an), .seg(seg),
      .digits(digits), .valid(valid), .invalid(invalid),
      .update(update), .update_idx(update_idx),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          c;
      int          idx;
      logic [15:0] d;
      logic [3:0]  v;
      logic [3:0]  iv;
      logic        fd;
   } exp_t;

   exp_t q[$];
   exp_t me;
   int total = 0;
   int passed = 0;

   logic [6:0]  pat[16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   logic [15:0] m_d, l_d;
   logic [3:0]  m_v, m_iv, m_seen, l_v, l_iv;

   always @(posedge clk) begin
      #1;
      if (!rst) begin
         if (update) begin
            total++;
            if (q.size() == 0) begin
               $display("FAIL unexpected_update idx=%0d cyc=%0d want none",
                        update_idx, cyc);
            end else begin
               me = q.pop_front();
               if (cyc !== me.c || int'(update_idx) !== me.idx ||
                   digits !== me.d || valid !== me.v ||
                   invalid !== me.iv || frame_done !== me.fd)
                  $display("FAIL commit got cyc=%0d idx=%0d d=%h v=%b iv=%b fd=%b want cyc=%0d idx=%0d d=%h v=%b iv=%b fd=%b",
                           cyc, update_idx, digits, valid, invalid, frame_done,
                           me.c, me.idx, me.d, me.v, me.iv, me.fd);
               else passed++;
               l_d  = me.d;
               l_v  = me.v;
               l_iv = me.iv;
            end
         end else begin
            total++;
            if ({digits, valid, invalid, frame_done} !==
                {l_d, l_v, l_iv, 1'b0})
               $display("FAIL hold cyc=%0d got d=%h v=%b iv=%b fd=%b want d=%h v=%b iv=%b fd=0",
                        cyc, digits, valid, invalid, frame_done, l_d, l_v, l_iv);
            else passed++;
         end
      end
   end

   task automatic push_commit(input logic [3:0] a, input logic [6:0] s,
                              input int c);
      int   i = 0;
      int   k = -1;
      logic fd;
      for (int j = 0; j < N; j++) if (!a[j]) i = j;
      for (int j = 0; j < 16; j++) if (pat[j] == s) k = j;
      if (k >= 0) begin
         m_d[4*i +: 4] = 4'(k);
         m_v[i]  = 1'b1;
         m_iv[i] = 1'b0;
      end else begin
         m_v[i]  = 1'b0;
         m_iv[i] = 1'b1;
      end
      m_seen[i] = 1'b1;
      fd = &m_seen;
      if (fd) m_seen = '0;
      q.push_back('{c, i, m_d, m_v, m_iv, fd});
   endtask

   task automatic dwell(input logic [3:0] a, input logic [6:0] s,
                        input int n);
      an  = a;
      seg = s;
      if (n >= S && $countones(~a) == 1) push_commit(a, s, cyc + S + 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      an  = 4'hF;
      seg = 7'h7F;
      m_d = '0; m_v = '0; m_iv = '0; m_seen = '0;
      l_d = '0; l_v = '0; l_iv = '0;
      q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      total++;
      if ({digits, valid, invalid, update, update_idx, frame_done} !== '0)
         $display("FAIL reset_state got d=%h v=%b iv=%b u=%b ui=%0d fd=%b want all 0",
                  digits, valid, invalid, update, update_idx, frame_done);
      else passed++;
   endtask

   task automatic test_legal_decode();
      apply_reset();
      dwell(4'b1011, 7'b0110000, 10);
      dwell(4'hF, 7'h7F, 4);
      total++;
      if (digits[11:8] !== 4'd3 || valid !== 4'b0100 || invalid !== 4'b0000 ||
          q.size() != 0)
         $display("FAIL legal_decode got d2=%h v=%b iv=%b pend=%0d want 3 0100 0000 0",
                  digits[11:8], valid, invalid, q.size());
      else passed++;
   endtask

   task automatic test_frame();
      logic [3:0] sel;
      apply_reset();
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < N; i++) begin
            sel = 4'b1 << i;
            dwell(~sel, pat[10+i], 6);
         end
      dwell(4'hF, 7'h7F, 6);
      total++;
      if (digits !== 16'hDCBA || valid !== 4'hF || q.size() != 0)
         $display("FAIL frame got d=%h v=%b pend=%0d want DCBA 1111 0",
                  digits, valid, q.size());
      else passed++;
   endtask

   task automatic test_short_glitch();
      apply_reset();
      dwell(4'b1101, pat[4], 3);
      dwell(4'hF, 7'h7F, 5);
      total++;
      if (update !== 1'b0 || valid !== 4'b0000 || q.size() != 0)
         $display("FAIL short_dwell got u=%b v=%b pend=%0d want 0 0000 0",
                  update, valid, q.size());
      else passed++;
      dwell(4'b1101, pat[9], 2);
      dwell(4'b1101, pat[1], 1);
      dwell(4'b1101, pat[9], 9);
      dwell(4'hF, 7'h7F, 4);
      total++;
      if (digits[7:4] !== 4'd9 || valid !== 4'b0010 || q.size() != 0)
         $display("FAIL glitch got d1=%h v=%b pend=%0d want 9 0010 0",
                  digits[7:4], valid, q.size());
      else passed++;
   endtask

   task automatic test_illegal();
      apply_reset();
      dwell(4'b1110, pat[7], 6);
      total++;
      if (valid[0] !== 1'b1 || digits[3:0] !== 4'd7)
         $display("FAIL pre_illegal got v0=%b d0=%h want 1 7",
                  valid[0], digits[3:0]);
      else passed++;
      dwell(4'b1110, 7'b1111111, 6);
      dwell(4'hF, 7'h7F, 4);
      total++;
      if (digits[3:0] !== 4'd7 || valid[0] !== 1'b0 || invalid[0] !== 1'b1 ||
          q.size() != 0)
         $display("FAIL illegal got d0=%h v0=%b iv0=%b pend=%0d want 7 0 1 0",
                  digits[3:0], valid[0], invalid[0], q.size());
      else passed++;
   endtask

   task automatic test_blank_multi();
      logic [23:0] snap;
      apply_reset();
      dwell(4'b0111, pat[12], 6);
      dwell(4'hF, 7'h7F, 2);
      snap = {digits, valid, invalid};
      dwell(4'b1111, pat[8], 20);
      dwell(4'b0011, pat[8], 20);
      total++;
      if ({digits, valid, invalid} !== snap || snap[23:20] !== 4'hC ||
          q.size() != 0)
         $display("FAIL blank_multi got %h want %h (d3=C) pend=%0d",
                  {digits, valid, invalid}, snap, q.size());
      else passed++;
   endtask

   task automatic test_reset_mid();
      apply_reset();
      dwell(4'b1101, pat[5], 6);
      an  = 4'b0111;
      seg = pat[8];
      repeat (3) @(negedge clk);
      rst = 1'b1;
      m_d = '0; m_v = '0; m_iv = '0; m_seen = '0;
      l_d = '0; l_v = '0; l_iv = '0;
      @(negedge clk);
      rst = 1'b0;
      total++;
      if ({digits, valid, invalid, update, frame_done} !== '0)
         $display("FAIL reset_mid got d=%h v=%b iv=%b u=%b fd=%b want all 0",
                  digits, valid, invalid, update, frame_done);
      else passed++;
      dwell(4'b0111, pat[8], 6);
      dwell(4'hF, 7'h7F, 4);
      total++;
      if (digits !== 16'h8000 || valid !== 4'b1000 || q.size() != 0)
         $display("FAIL reset_mid_commit got d=%h v=%b pend=%0d want 8000 1000 0",
                  digits, valid, q.size());
      else passed++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout cyc=%0d want finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      test_reset();
      test_legal_decode();
      test_frame();
      test_short_glitch();
      test_illegal();
      test_blank_multi();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Recovers hex digit values from a time-multiplexed, active-low 7-segment display bus (digit enables plus segment lines). This is the inverse of the hex-to-segment encoder used on the display path. The block samples the bus and debounces each digit's dwell period. It decodes each stable segment pattern back to a 4-bit value and holds a per-digit register file with validity flags. It sits on the board-test and loopback path, watching the same display bus that drives the physical display.

## Interface

Parameters:
- `NUM_DIGITS`, default 4: number of multiplexed digits (2..8).
- `STABLE_CYCLES`, default 4: number of consecutive identical samples required before a commit (2..255).

Ports:
- `clk`, input, 1: single clock; all logic on its rising edge.
- `rst`, input, 1: reset, **synchronous, active-high**.
- `an`, input, `NUM_DIGITS`: digit enables, active-low. Exactly one bit at 0 selects a digit.
- `seg`, input, 7: segments, active-low. Bit 0 = a … bit 6 = g.
- `digits`, output, `4*NUM_DIGITS`: decoded values. Digit i occupies `[4i+3:4i]`.
- `valid`, output, `NUM_DIGITS`: the last commit for digit i was a legal pattern.
- `invalid`, output, `NUM_DIGITS`: the last commit for digit i was an illegal pattern.
- `update`, output, 1: one-cycle pulse on every commit.
- `update_idx`, output, `$clog2(NUM_DIGITS)`: digit index of the current commit. Meaningful only while `update` is high.
- `frame_done`, output, 1: one-cycle pulse when every digit has committed at least once since the previous pulse.

## Operation

- Legal patterns (`seg[6:0]` → value):
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3
  - 0011001→4, 0010010→5, 0000010→6, 1111000→7
  - 0000000→8, 0010000→9, 0001000→A, 0000011→b
  - 1000110→C, 0100001→d, 0000110→E, 0001110→F
- Any other pattern is illegal.
- Sample registers `s_an` and `s_seg` capture the inputs every cycle. A stability counter `cnt` saturates at `STABLE_CYCLES`.
- State machine:
  - **IDLE**: `an` is not one-hot-low (all ones, or more than one zero). `cnt`=0.
    - On a one-hot `an`: → TRACK, `cnt`=1.
  - **TRACK**: if (`an`,`seg`) equals the sample registers, `cnt`++.
    - When `cnt` reaches `STABLE_CYCLES`: commit, → HOLD.
    - On a change to another one-hot value: stay in TRACK, `cnt`=1.
    - On a non-one-hot `an`: → IDLE.
  - **HOLD**: no further commits while the inputs stay equal.
    - Any change: → TRACK (`cnt`=1) or → IDLE, same rules as above.
- A new segment pattern on the same digit causes a fresh commit after `STABLE_CYCLES` samples.
- Commit for digit i:
  - Legal pattern: `digits[i]` ← decoded value, `valid[i]`=1, `invalid[i]`=0.
  - Illegal pattern: `digits[i]` unchanged, `valid[i]`=0, `invalid[i]`=1.
  - Always: `update`=1, `update_idx`=i, and seen-mask bit i is set.
- When the seen mask becomes all ones on a commit:
  - `frame_done`=1 in the same cycle as that `update`.
  - The mask clears to 0.
  - Re-commits of an already-seen digit do not advance the frame.

## Timing

- Reset values: `digits`=0, `valid`=0, `invalid`=0, `update`=0, `update_idx`=0, `frame_done`=0, seen mask=0, `cnt`=0, state IDLE.
- Reset is sampled at the clock edge. A reset mid-dwell discards partial counts. After `rst` falls, a full `STABLE_CYCLES` run is needed again.
- Latency: with inputs constant from before edge E0, `cnt` reaches `STABLE_CYCLES` at edge E(S-1). `update` and the outputs become visible after edge E(S), i.e. S+1 edges from first presentation.
  - Example, S=4: edges E0..E4; `update` is high for exactly one cycle after E4.
- `update` and `frame_done` are registered single-cycle pulses. They never stay high on consecutive cycles for the same dwell.
- Dwells shorter than `STABLE_CYCLES` samples produce no commit and leave all outputs unchanged.
- A single-cycle glitch inside a dwell restarts counting. Exactly one commit follows once the pattern is restable for S samples.
- `digits`, `valid` and `invalid` change only on a commit edge.

## Test plan

1. **Legal decode on digit 2.** Reset, then hold `an`=1011, `seg`=0110000 for 10 cycles. Expect one `update` pulse 5 edges after presentation, `update_idx`=2, `digits[11:8]`=3, `valid`=0100, `invalid`=0000.
2. **Full scan frame.** Scan digits 0..3 with patterns for A, b, C, d, 6 cycles each. Expect 4 `update` pulses, `digits`=0xDCBA, and `frame_done` coinciding with the 4th `update`. A second identical scan gives a second `frame_done`.
3. **Short dwell and glitch.** Dwell of 3 cycles on digit 1 → no `update`. On a 12-cycle dwell, flip `seg` for 1 cycle at cycle 2 → exactly one commit, of the final pattern.
4. **Illegal pattern.** Digit 0 holds 7 (`valid[0]`=1), then `seg`=1111111 for 6 cycles. Expect `update`, `invalid[0]`=1, `valid[0]`=0, `digits[3:0]` still 7.
5. **Blank and multi-hot enables.** `an`=1111 or 0011 for 20 cycles → no `update`; all outputs unchanged.
6. **Reset mid-dwell.** Assert `rst` at cycle 3 of a stable dwell, release it, and continue the same input. Expect all outputs at their reset values, then a commit 5 edges after release.
